twiddle_angle_sequencer: RTL and testbench
==========================================

# twiddle_angle_sequencer

Streaming front end for one radix-2 SDF CORDIC FFT stage. It accepts complex samples and keeps a frame index. For each sample it drives the address of the stage's registered twiddle-angle ROM and absorbs that ROM's 1-cycle read latency. It then emits each sample paired with its rotation angle to the downstream CORDIC rotator under valid/ready flow control.

## Interface
- ADDR_W, 8: ROM address width. Frame length is FRAME = 2^(ADDR_W+1) samples.
- DATA_W, 64: complex sample width ({re, im} float32).
- ANGLE_W, 32: angle word width (IEEE-754 float32 radians).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_clear  in  1  synchronous frame resync; forces the frame index to 0.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_data  in  DATA_W  input sample.
- o_rom_addr  out  ADDR_W  address to the angle ROM, which registers its output.
- i_rom_data  in  ANGLE_W  ROM output; value for the address presented on the previous cycle.
- o_valid  out  1  output pair valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  sample.
- o_angle  out  ANGLE_W  rotation angle for o_data.
- o_rot_en  out  1  rotation required; 0 = pass-through half of the frame.
- o_last  out  1  last sample of the frame.

## Operation
- A sample is accepted when i_valid && o_ready. A sample is output when o_valid && i_ready.
- Frame index cnt, ADDR_W+1 bits:
  - increments by 1 on every accept;
  - wraps FRAME-1 -> 0.
- Index k used for the accepted sample:
  - k = 0 if i_clear is high that cycle, else k = cnt;
  - after the accept, cnt <= k+1.
  - i_clear without an accept sets cnt <= 0.
- Flags for index k:
  - rot_en = k[ADDR_W].
  - last = (k == FRAME-1).
- o_rom_addr is combinational from k:
  - equals k[ADDR_W-1:0] when rot_en = 1;
  - equals 0 otherwise.
- Stage s1 is a registered holding stage:
  - loaded on accept with {sample, rot_en, last}, s1_valid <= 1;
  - cleared when no accept occurs.
- Output FIFO, 3 entries, storing {data, angle, rot_en, last}:
  - whenever s1_valid = 1, the entry {s1 sample, angle, s1 flags} is pushed unconditionally in that cycle;
  - angle = i_rom_data if s1 rot_en = 1, else 32'h00000000 (+0.0). The ROM value is ignored for pass-through samples.
- o_ready = (fifo_count + s1_valid) < 3. It is combinational from state only and never depends on i_valid or i_ready.
- Invariant: fifo_count + s1_valid <= 3. A push into a full FIFO is impossible; the bench asserts it.
- Outputs come from the FIFO head:
  - o_valid = (fifo_count != 0);
  - o_data, o_angle, o_rot_en and o_last hold stable while o_valid && !i_ready.
- Simultaneous push and pop: count is unchanged and order is preserved.

## Timing
- Latency: accept at cycle t -> ROM read at t -> s1 and i_rom_data aligned at t+1 -> push at end of t+1 -> o_valid at t+2 at the earliest.
- Throughput is 1 sample/cycle sustained while i_ready = 1, with no bubbles.
- Reset (i_rst_n low at a clock edge):
  - cnt = 0, s1_valid = 0, FIFO empty;
  - o_valid = 0, o_data = 0, o_angle = 0, o_rot_en = 0, o_last = 0;
  - o_ready = 0 while reset is asserted and 1 in the first cycle after release;
  - o_rom_addr = 0.
- Reset mid-frame discards s1 and all FIFO contents. The next accepted sample has index 0.
- Backpressure: with i_ready = 0 and a continuous input, exactly 3 samples are accepted after the FIFO drains. o_ready then drops and stays 0 until a pop.
- i_clear does not flush s1 or the FIFO. In-flight samples keep the indices already assigned to them.

## Test plan
- Reset then stream: apply reset, then 512 back-to-back samples with i_ready = 1, ADDR_W = 8, and a ROM model returning {24'h0, addr} one cycle late.
  - Samples 0..255: o_rot_en = 0, o_angle = 0.
  - Sample 256: angle 32'h00000000, rot_en = 1.
  - Sample 257: angle 32'h00000001.
  - Sample 511: angle 32'h000000FF, o_last = 1.
  - First o_valid exactly 2 cycles after the first accept.
- Wrap: continue with sample 512.
  - Index is 0, rot_en = 0, o_last = 0.
  - No bubble across the frame boundary.
- Backpressure: hold i_ready = 0 during a continuous input.
  - Exactly 3 accepts, then o_ready = 0.
  - Release i_ready: outputs emerge in order with correct angles, no loss or duplication.
- Random stall: random i_valid/i_ready (50%) over 2048 samples.
  - Output sequence equals the input sequence.
  - Each angle matches index mod 512.
  - Assertion fifo_count + s1_valid <= 3 never fires.
- Clear: assert i_clear with an accept at index 300.
  - That sample gets index 0 (rot_en = 0).
  - The next sample gets index 1.
  - Previously accepted samples keep their original angles.
- Reset mid-operation: assert i_rst_n = 0 with 2 FIFO entries and s1 valid.
  - Next cycle o_valid = 0.
  - After release, o_ready = 1 and the first new sample has index 0.

Source files
------------

// File: rtl/twiddle_angle_sequencer.sv
// twiddle_angle_sequencer
//   Streaming front end for one radix-2 SDF CORDIC FFT stage. Tracks the
//   frame index of each accepted sample, drives the twiddle-angle ROM
//   address, absorbs the ROM's one-cycle read latency in holding stage s1,
//   and presents {sample, angle, rot_en, last} from a 3-entry output FIFO
//   under valid/ready flow control.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_clear            frame resync: index of this cycle's sample forced to 0
//   i_valid/o_ready    input handshake, i_data the sample
//   o_rom_addr         angle ROM address (ROM registers its output)
//   i_rom_data         ROM data for the address presented last cycle
//   o_valid/i_ready    output handshake
//   o_data, o_angle    sample and its rotation angle
//   o_rot_en, o_last   rotate flag (0 = pass-through half), last of frame
module twiddle_angle_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int ANGLE_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [ANGLE_W-1:0] i_rom_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [ANGLE_W-1:0] o_angle,
  output logic               o_rot_en,
  output logic               o_last
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_W + ANGLE_W + 2;
  localparam int DEPTH   = 3;

  // Wrap a FIFO pointer over the three entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]  s1_data_q, s1_data_d;
  logic               s1_rot_en_q, s1_rot_en_d;
  logic               s1_last_q, s1_last_d;
  logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
  logic [ENTRY_W-1:0] fifo_mem_d [DEPTH];
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]         fifo_count_q, fifo_count_d;

  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   k_s;
  logic               rot_en_k_s;
  logic               last_k_s;
  logic [2:0]         occupancy_s;
  logic [ANGLE_W-1:0] push_angle_s;
  logic [ENTRY_W-1:0] push_entry_s;
  logic [ENTRY_W-1:0] head_s;

  // Handshakes, index selection and ROM addressing.
  always_comb begin
    occupancy_s = {1'b0, fifo_count_q} + {2'b00, s1_valid_q};
    // Counting s1 in the occupancy guarantees the unconditional push from s1
    // always finds a free FIFO slot.
    o_ready     = i_rst_n && (occupancy_s < 3'd3);
    accept_s    = i_valid && o_ready;
    k_s         = i_clear ? {CNT_W{1'b0}} : cnt_q;
    rot_en_k_s  = k_s[ADDR_W];
    last_k_s    = (k_s == {CNT_W{1'b1}});
    if (rot_en_k_s) begin
      o_rom_addr = k_s[ADDR_W-1:0];
    end else begin
      o_rom_addr = {ADDR_W{1'b0}};
    end
    o_valid = (fifo_count_q != 2'd0);
    pop_s   = o_valid && i_ready;
    push_s  = s1_valid_q;
  end

  // Frame index and s1 holding-stage next state.
  always_comb begin
    cnt_d       = cnt_q;
    s1_valid_d  = 1'b0;
    s1_data_d   = s1_data_q;
    s1_rot_en_d = s1_rot_en_q;
    s1_last_d   = s1_last_q;
    if (accept_s) begin
      cnt_d       = k_s + {{(CNT_W-1){1'b0}}, 1'b1};
      s1_valid_d  = 1'b1;
      s1_data_d   = i_data;
      s1_rot_en_d = rot_en_k_s;
      s1_last_d   = last_k_s;
    end else if (i_clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIFO write data, storage, pointers and occupancy.
  always_comb begin
    // i_rom_data is aligned with s1; pass-through samples ignore it.
    if (s1_rot_en_q) begin
      push_angle_s = i_rom_data;
    end else begin
      push_angle_s = {ANGLE_W{1'b0}};
    end
    push_entry_s = {s1_data_q, push_angle_s, s1_rot_en_q, s1_last_q};
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_ptr_q == 2'(i))) begin
        fifo_mem_d[i] = push_entry_s;
      end else begin
        fifo_mem_d[i] = fifo_mem_q[i];
      end
    end
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Head-of-FIFO output mux; outputs hold while the head is not popped.
  always_comb begin
    head_s = {ENTRY_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == 2'(i)) begin
        head_s = fifo_mem_q[i];
      end else begin
        head_s = head_s;
      end
    end
    o_data   = head_s[ENTRY_W-1 -: DATA_W];
    o_angle  = head_s[ANGLE_W+1 -: ANGLE_W];
    o_rot_en = head_s[1];
    o_last   = head_s[0];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_data_q    <= {DATA_W{1'b0}};
      s1_rot_en_q  <= 1'b0;
      s1_last_q    <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      fifo_count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_rot_en_q  <= s1_rot_en_d;
      s1_last_q    <= s1_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_twiddle_angle_sequencer.sv
// Scoreboard bench for twiddle_angle_sequencer (ADDR_W = 8, FRAME = 512).
// A reference index model pushes the expected {data, angle, rot_en, last}
// on every accept; a monitor pops and compares on every output transfer.
module tb_twiddle_angle_sequencer;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] angle;
    logic        rot_en;
    logic        last;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clear;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_data;
  logic [7:0]  o_rom_addr;
  logic [31:0] i_rom_data;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_data;
  logic [31:0] o_angle;
  logic        o_rot_en;
  logic        o_last;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  logic [8:0]  model_cnt = 9'd0;
  logic [8:0]  model_k;
  exp_t        model_e;
  exp_t        mon_e;
  logic [31:0] seq = 32'd0;

  twiddle_angle_sequencer #(.ADDR_W(8), .DATA_W(64), .ANGLE_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_angle(o_angle), .o_rot_en(o_rot_en), .o_last(o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Registered ROM model: data = {24'h0, addr}, one cycle late.
  always @(posedge i_clk) i_rom_data <= {24'h0, o_rom_addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] s);
    mk = {s ^ 32'hC0DE_0000, s};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: index, flags and angle of every accepted sample.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      sb.delete();
      model_cnt = 9'd0;
    end else begin
      model_k = i_clear ? 9'd0 : model_cnt;
      if (i_valid && o_ready) begin
        model_e.data   = i_data;
        model_e.rot_en = model_k[8];
        model_e.last   = (model_k == 9'h1FF);
        model_e.angle  = model_k[8] ? {24'h0, model_k[7:0]} : 32'h0;
        sb.push_back(model_e);
        model_cnt = model_k + 9'd1;
      end else if (i_clear) begin
        model_cnt = 9'd0;
      end
    end
  end

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      check("occupancy_le_3",
            64'((32'(dut.fifo_count_q) + 32'(dut.s1_valid_q)) <= 32'd3), 64'd1);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %h expected none", o_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data",   o_data,          mon_e.data);
          check("out_angle",  64'(o_angle),    64'(mon_e.angle));
          check("out_rot_en", 64'(o_rot_en),   64'(mon_e.rot_en));
          check("out_last",   64'(o_last),     64'(mon_e.last));
          case (mon_e.data[31:0])
            32'd256: begin
              check("s256_rot_en", 64'(o_rot_en), 64'd1);
              check("s256_angle",  64'(o_angle),  64'h0);
            end
            32'd257: check("s257_angle", 64'(o_angle), 64'h1);
            32'd511: begin
              check("s511_angle", 64'(o_angle), 64'hFF);
              check("s511_last",  64'(o_last),  64'd1);
            end
            32'd512: begin
              check("s512_rot_en", 64'(o_rot_en), 64'd0);
              check("s512_last",   64'(o_last),   64'd0);
            end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bubbles;
    int acc;
    int cyc;
    logic take;
    i_rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_data = 64'h0;
    repeat (3) step();
    // Reset state
    check("rst_o_ready",    64'(o_ready),    64'd0);
    check("rst_o_valid",    64'(o_valid),    64'd0);
    check("rst_o_data",     o_data,          64'h0);
    check("rst_o_angle",    64'(o_angle),    64'h0);
    check("rst_o_rot_en",   64'(o_rot_en),   64'd0);
    check("rst_o_last",     64'(o_last),     64'd0);
    check("rst_o_rom_addr", 64'(o_rom_addr), 64'h0);
    i_rst_n = 1'b1;
    #1;
    check("rel_o_ready", 64'(o_ready), 64'd1);

    // Back-to-back stream across the frame wrap
    bubbles = 0;
    for (int i = 0; i < 516; i++) begin
      i_data = mk(seq); i_valid = 1'b1;
      step();
      seq++;
      if (i == 0) check("latency_t1_valid", 64'(o_valid), 64'd0);
      if (i == 1) check("latency_t2_valid", 64'(o_valid), 64'd1);
      if (i >= 1 && !o_valid) bubbles++;
    end
    check("stream_no_bubble", 64'(bubbles), 64'd0);
    i_valid = 1'b0;
    repeat (5) step();

    // Backpressure: three accepts from empty, then o_ready stays low
    i_ready = 1'b0; i_valid = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      i_data = mk(seq);
      take = o_ready;
      step();
      if (take) begin acc++; seq++; end
    end
    check("bp_accepts", 64'(acc), 64'd3);
    check("bp_o_ready", 64'(o_ready), 64'd0);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (6) step();

    // Random stall over 2048 samples
    acc = 0; cyc = 0;
    while (acc < 2048 && cyc < 30000) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_data  = mk(seq);
      take = i_valid && o_ready;
      step();
      cyc++;
      if (take) begin acc++; seq++; end
    end
    check("random_done", 64'(acc), 64'd2048);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (8) step();

    // Clear on the accept at index 300
    cyc = 0;
    while (model_cnt != 9'd300 && cyc < 600) begin
      i_data = mk(seq); i_valid = 1'b1;
      step();
      seq++; cyc++;
    end
    check("clear_reach_300", 64'(model_cnt), 64'd300);
    i_data = mk(seq);
    check("idx300_rom_addr", 64'(o_rom_addr), 64'd44);
    i_clear = 1'b1;
    #1;
    check("clear_rom_addr", 64'(o_rom_addr), 64'd0);
    step();
    seq++;
    i_clear = 1'b0;
    i_data = mk(seq);
    step();
    seq++;
    i_valid = 1'b0;
    repeat (6) step();

    // Reset mid-operation with 2 FIFO entries and s1 valid
    cyc = 0;
    while (model_cnt != 9'd400 && cyc < 600) begin
      i_data = mk(seq); i_valid = 1'b1;
      step();
      seq++; cyc++;
    end
    i_valid = 1'b0;
    repeat (4) step();
    i_ready = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = mk(seq);
      step();
      seq++;
    end
    i_valid = 1'b0;
    check("pre_rst_valid", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0;
    step();
    check("mid_rst_o_valid", 64'(o_valid), 64'd0);
    check("mid_rst_o_ready", 64'(o_ready), 64'd0);
    i_rst_n = 1'b1; i_ready = 1'b1;
    #1;
    check("mid_rel_o_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      i_data = mk(seq); i_valid = 1'b1;
      step();
      seq++;
    end
    i_valid = 1'b0;
    repeat (6) step();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
